// File: rtl/seq_divider_pkg.sv
// Shared state encoding and default operand widths for the sequential divider.
package seq_divider_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_M = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: compare the shifted partial remainder with the divisor and subtract on success.
// Purely combinational, no backpressure.
module div_step #(
  parameter int M = 4
) (
  input  logic [M:0]   i_rem,
  input  logic [M-1:0] i_divisor,
  output logic [M-1:0] o_rem,
  output logic         o_qbit
);

  logic [M:0] w_div_ext;
  logic [M:0] w_diff;

  assign w_div_ext = {1'b0, i_divisor};
  assign w_diff    = i_rem - w_div_ext;
  assign o_qbit    = (i_rem >= w_div_ext);
  // A non-zero divisor always leaves a result below 2^M; with a zero divisor the dropped top
  // bit would be shifted out on the next step anyway.
  assign o_rem     = o_qbit ? w_diff[M-1:0] : i_rem[M-1:0];

endmodule

// File: rtl/seq_divider.sv
// Unsigned N/M-bit restoring divider, one quotient bit per cycle; result N cycles after acceptance,
// held in DONE until out_ready. Optional SEQ_DIVIDER_DBZ_EN adds a dbz flag and a 1-cycle divide-by-zero path.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder
`ifdef SEQ_DIVIDER_DBZ_EN
  ,
  output logic         dbz
`endif
);

  localparam int CW = $clog2(N + 1);

  state_e        r_state;
  logic [N-1:0]  r_q;
  logic [M-1:0]  r_rem;
  logic [M-1:0]  r_div;
  logic [CW-1:0] r_cnt;
`ifdef SEQ_DIVIDER_DBZ_EN
  logic          r_dbz;
`endif

  logic [M:0]    w_rem_sh;
  logic [M-1:0]  w_rem_nxt;
  logic          w_qbit;
  logic          w_accept;
  logic          w_last;

  assign w_rem_sh = {r_rem, r_q[N-1]};
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == CW'(N - 1));

  div_step #(.M(M)) u_step (
    .i_rem     (w_rem_sh),
    .i_divisor (r_div),
    .o_rem     (w_rem_nxt),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
`ifdef SEQ_DIVIDER_DBZ_EN
      r_dbz   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_q     <= dividend;
            r_div   <= divisor;
            r_rem   <= '0;
            r_cnt   <= '0;
`ifdef SEQ_DIVIDER_DBZ_EN
            r_dbz   <= 1'b0;
`endif
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
`ifdef SEQ_DIVIDER_DBZ_EN
          if (r_div == '0) begin
            r_q     <= '1;
            r_rem   <= '0;
            r_dbz   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_rem <= w_rem_nxt;
            r_q   <= {r_q[N-2:0], w_qbit};
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_state <= S_DONE;
          end
`else
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[N-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= S_DONE;
`endif
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gated by rst_n so in_ready stays low for the whole reset assertion.
  assign in_ready  = (r_state == S_IDLE) && rst_n;
  assign out_valid = (r_state == S_DONE);
  assign quotient  = r_q;
  assign remainder = r_rem;
`ifdef SEQ_DIVIDER_DBZ_EN
  assign dbz       = r_dbz;
`endif

endmodule
